// File: rtl/bus_pkg.sv
// Shared bus definitions: op codes, CPU ids, responder
// states and default widths used across the bus slice.
package bus_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 4;

  localparam logic OP_READ      = 1'b0;
  localparam logic OP_WRITEBACK = 1'b1;

  localparam logic CPU1 = 1'b0;
  localparam logic CPU2 = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Shared word memory: sync write, comb read,
// and each word resets to its own index.
module mem_array
  import bus_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Reset loads index pattern; otherwise write on we.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= DATA_W'(i);
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/bus_memory_responder.sv
// Memory end of the snooping bus: one outstanding
// read-miss or write-back, answered after LATENCY cycles.
module bus_memory_responder
  import bus_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              bus_req,
  input  logic              bus_op,
  input  logic              bus_src,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_abort,
  output logic              bus_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_dst,
  input  logic              resp_ack,
  output logic [1:0]        state_out,
  output logic [7:0]        txn_count
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              op_q;
  logic              src_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata;
  logic              mem_we;

  // Write-backs commit on the final access cycle;
  // abort does not apply to them.
  assign mem_we = (state == ACCESS) &&
                  (cnt == 4'd0) &&
                  (op_q == OP_WRITEBACK);

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clock(clock),
    .reset(reset),
    .we   (mem_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(rdata)
  );

  assign bus_ready  = (state == IDLE);
  assign resp_valid = (state == RESPOND);
  assign state_out  = state;

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      op_q      <= OP_READ;
      src_q     <= CPU1;
      addr_q    <= '0;
      wdata_q   <= '0;
      resp_data <= '0;
      resp_dst  <= CPU1;
      txn_count <= 8'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus_req) begin
            op_q    <= bus_op;
            src_q   <= bus_src;
            addr_q  <= bus_addr;
            wdata_q <= bus_wdata;
            cnt     <= CNT_INIT;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (op_q == OP_READ && bus_abort) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            resp_data <= (op_q == OP_WRITEBACK)
                         ? wdata_q : rdata;
            resp_dst  <= src_q;
            state     <= RESPOND;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESPOND: begin
          if (resp_ack) begin
            state <= IDLE;
            if (txn_count != 8'hFF)
              txn_count <= txn_count + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder at LATENCY=2,
// one task per scenario with inline checks.
module tb_bus_memory_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       bus_req;
  logic       bus_op;
  logic       bus_src;
  logic [2:0] bus_addr;
  logic [3:0] bus_wdata;
  logic       bus_abort;
  logic       bus_ready;
  logic       resp_valid;
  logic [3:0] resp_data;
  logic       resp_dst;
  logic       resp_ack;
  logic [1:0] state_out;
  logic [7:0] txn_count;

  int tests = 0;
  int fails = 0;

  bus_memory_responder #(
    .LATENCY(2),
    .ADDR_W (3),
    .DATA_W (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus_req   (bus_req),
    .bus_op    (bus_op),
    .bus_src   (bus_src),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_abort (bus_abort),
    .bus_ready (bus_ready),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_dst  (resp_dst),
    .resp_ack  (resp_ack),
    .state_out (state_out),
    .txn_count (txn_count)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic op,
                       input logic src,
                       input logic [2:0] addr,
                       input logic [3:0] wd);
    bus_req   = 1'b1;
    bus_op    = op;
    bus_src   = src;
    bus_addr  = addr;
    bus_wdata = wd;
    step();
    bus_req = 1'b0;
  endtask

  task automatic ack();
    resp_ack = 1'b1;
    step();
    resp_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    tests++;
    if (bus_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b exp 1", bus_ready);
    end
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %b exp 0", resp_valid);
    end
    tests++;
    if (resp_data !== 4'h0 || resp_dst !== 1'b0) begin
      fails++;
      $display("FAIL reset_resp got %h/%b exp 0/0",
               resp_data, resp_dst);
    end
    tests++;
    if (txn_count !== 8'd0 || state_out !== 2'b00) begin
      fails++;
      $display("FAIL reset_cnt_state got %0d/%b exp 0/00",
               txn_count, state_out);
    end
  endtask

  task automatic test_read();
    issue(1'b0, 1'b0, 3'd5, 4'h0);
    tests++;
    if (bus_ready !== 1'b0 || state_out !== 2'b01) begin
      fails++;
      $display("FAIL read_accept got %b/%b exp 0/01",
               bus_ready, state_out);
    end
    step();
    tests++;
    if (resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL read_early got %b exp 0", resp_valid);
    end
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 4'h5 ||
        resp_dst !== 1'b0) begin
      fails++;
      $display("FAIL read_resp got %b/%h/%b exp 1/5/0",
               resp_valid, resp_data, resp_dst);
    end
    ack();
    tests++;
    if (state_out !== 2'b00 || txn_count !== 8'd1) begin
      fails++;
      $display("FAIL read_ack got %b/%0d exp 00/1",
               state_out, txn_count);
    end
  endtask

  task automatic test_writeback();
    issue(1'b1, 1'b1, 3'd3, 4'hA);
    step();
    step();
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 4'hA ||
        resp_dst !== 1'b1) begin
      fails++;
      $display("FAIL wb_resp got %b/%h/%b exp 1/a/1",
               resp_valid, resp_data, resp_dst);
    end
    ack();
    issue(1'b0, 1'b0, 3'd3, 4'h0);
    step();
    step();
    tests++;
    if (resp_data !== 4'hA || resp_dst !== 1'b0) begin
      fails++;
      $display("FAIL wb_readback got %h/%b exp a/0",
               resp_data, resp_dst);
    end
    ack();
    tests++;
    if (txn_count !== 8'd3) begin
      fails++;
      $display("FAIL wb_count got %0d exp 3", txn_count);
    end
  endtask

  task automatic test_abort();
    issue(1'b0, 1'b0, 3'd6, 4'h0);
    bus_abort = 1'b1;
    step();
    bus_abort = 1'b0;
    tests++;
    if (state_out !== 2'b00 || resp_valid !== 1'b0 ||
        bus_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle got %b/%b/%b exp 00/0/1",
               state_out, resp_valid, bus_ready);
    end
    step();
    tests++;
    if (resp_valid !== 1'b0 || txn_count !== 8'd3) begin
      fails++;
      $display("FAIL abort_noresp got %b/%0d exp 0/3",
               resp_valid, txn_count);
    end
    issue(1'b0, 1'b1, 3'd6, 4'h0);
    step();
    step();
    tests++;
    if (resp_data !== 4'h6 || resp_dst !== 1'b1) begin
      fails++;
      $display("FAIL abort_mem got %h/%b exp 6/1",
               resp_data, resp_dst);
    end
    ack();
  endtask

  task automatic test_write_abort();
    issue(1'b1, 1'b0, 3'd2, 4'h7);
    bus_abort = 1'b1;
    step();
    tests++;
    if (state_out !== 2'b01) begin
      fails++;
      $display("FAIL wabort_state got %b exp 01", state_out);
    end
    step();
    bus_abort = 1'b0;
    tests++;
    if (resp_valid !== 1'b1 || resp_data !== 4'h7 ||
        resp_dst !== 1'b0) begin
      fails++;
      $display("FAIL wabort_resp got %b/%h/%b exp 1/7/0",
               resp_valid, resp_data, resp_dst);
    end
    ack();
    issue(1'b0, 1'b1, 3'd2, 4'h0);
    step();
    step();
    tests++;
    if (resp_data !== 4'h7 || resp_dst !== 1'b1) begin
      fails++;
      $display("FAIL wabort_read got %h/%b exp 7/1",
               resp_data, resp_dst);
    end
    ack();
    tests++;
    if (txn_count !== 8'd6) begin
      fails++;
      $display("FAIL wabort_count got %0d exp 6", txn_count);
    end
  endtask

  task automatic test_ack_hold();
    issue(1'b0, 1'b1, 3'd4, 4'h0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (resp_valid !== 1'b1 || resp_data !== 4'h4 ||
          resp_dst !== 1'b1) begin
        fails++;
        $display("FAIL hold_%0d got %b/%h/%b exp 1/4/1",
                 i, resp_valid, resp_data, resp_dst);
      end
      step();
    end
    resp_ack  = 1'b1;
    bus_req   = 1'b1;
    bus_op    = 1'b0;
    bus_src   = 1'b0;
    bus_addr  = 3'd7;
    step();
    resp_ack = 1'b0;
    tests++;
    if (state_out !== 2'b00 || txn_count !== 8'd7) begin
      fails++;
      $display("FAIL hold_noaccept got %b/%0d exp 00/7",
               state_out, txn_count);
    end
    step();
    bus_req = 1'b0;
    tests++;
    if (state_out !== 2'b01) begin
      fails++;
      $display("FAIL hold_accept got %b exp 01", state_out);
    end
    step();
    step();
    tests++;
    if (resp_data !== 4'h7 || resp_dst !== 1'b0) begin
      fails++;
      $display("FAIL hold_next got %h/%b exp 7/0",
               resp_data, resp_dst);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b1, 3'd1, 4'hF);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++;
    if (state_out !== 2'b00 || txn_count !== 8'd0 ||
        resp_valid !== 1'b0 || bus_ready !== 1'b1) begin
      fails++;
      $display("FAIL rmid_state got %b/%0d/%b/%b exp 00/0/0/1",
               state_out, txn_count, resp_valid, bus_ready);
    end
    tests++;
    if (resp_data !== 4'h0 || resp_dst !== 1'b0) begin
      fails++;
      $display("FAIL rmid_resp got %h/%b exp 0/0",
               resp_data, resp_dst);
    end
    issue(1'b0, 1'b0, 3'd1, 4'h0);
    step();
    step();
    tests++;
    if (resp_data !== 4'h1) begin
      fails++;
      $display("FAIL rmid_addr1 got %h exp 1", resp_data);
    end
    ack();
    issue(1'b0, 1'b0, 3'd3, 4'h0);
    step();
    step();
    tests++;
    if (resp_data !== 4'h3) begin
      fails++;
      $display("FAIL rmid_addr3 got %h exp 3", resp_data);
    end
    ack();
    tests++;
    if (txn_count !== 8'd2) begin
      fails++;
      $display("FAIL rmid_count got %0d exp 2", txn_count);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 256; i++) begin
      issue(1'b0, 1'b0, 3'(i), 4'h0);
      step();
      step();
      ack();
    end
    tests++;
    if (txn_count !== 8'd255) begin
      fails++;
      $display("FAIL sat_count got %0d exp 255", txn_count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    bus_req   = 1'b0;
    bus_op    = 1'b0;
    bus_src   = 1'b0;
    bus_addr  = 3'd0;
    bus_wdata = 4'h0;
    bus_abort = 1'b0;
    resp_ack  = 1'b0;
    #1;
    test_reset();
    test_read();
    test_writeback();
    test_abort();
    test_write_abort();
    test_ack_hold();
    test_reset_mid();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Memory-side end of the two-CPU snooping bus: accepts read-miss and write-back transactions issued by the bus arbiter and answers them from an 8 x 4-bit shared memory after a fixed access latency.
- Single outstanding transaction; a snoop-abort lets a cache that owns the line cancel a pending read.
- Sits under the bus block, beside the per-CPU cache controllers; its state is brought out for board LEDs.

Parameters:
- LATENCY, 2, access cycles between acceptance and result (legal 1..15)
- ADDR_W, 3, address width (memory depth = 2**ADDR_W)
- DATA_W, 4, word width

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- bus_req  input  1  transaction request from the bus
- bus_op  input  1  0 = read miss, 1 = write-back
- bus_src  input  1  requesting CPU: 0 = cpu1, 1 = cpu2
- bus_addr  input  ADDR_W  word address
- bus_wdata  input  DATA_W  write-back data
- bus_abort  input  1  snoop hit on a Modified line; cancels the pending read
- bus_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  response available
- resp_data  output  DATA_W  read data, or echo of written data
- resp_dst  output  1  CPU the response belongs to
- resp_ack  input  1  bus has consumed the response
- state_out  output  2  FSM state encoding, for LEDs
- txn_count  output  8  completed transactions, saturates at 255

Behaviour:
- Reset, synchronous:
  - state IDLE; bus_ready 1; resp_valid 0; resp_data 0; resp_dst 0; txn_count 0; state_out 2'b00.
  - mem[i] = i mod 2**DATA_W.
  - Reset has priority over every other input. Reset mid-transaction discards the transaction with no memory update.
- States (state_out encoding): IDLE 00, ACCESS 01, RESPOND 10; 11 is unused and recovers to IDLE.
- IDLE:
  - bus_ready = 1.
  - bus_req high at a rising edge accepts the request: op, src, addr and wdata are latched, the counter is loaded with LATENCY-1, and the FSM goes to ACCESS.
- ACCESS:
  - bus_ready = 0; bus_req is ignored. The counter decrements each cycle.
  - When the counter is 0:
    - read: resp_data <= mem[addr].
    - write: mem[addr] <= wdata and resp_data <= wdata.
    - Then go to RESPOND.
  - bus_abort high during a read: go to IDLE next edge. No response, no txn_count increment, memory untouched.
  - bus_abort during a write is ignored.
  - An abort on the same edge as counter = 0 wins; no response is produced.
- RESPOND:
  - resp_valid = 1. resp_data and resp_dst are held stable until acknowledged.
  - resp_ack high: go to IDLE; txn_count increments unless it is 255.
  - bus_ready stays 0 in the ack cycle, so a request coincident with resp_ack is not accepted; it is accepted one cycle later in IDLE.
  - bus_abort is ignored in RESPOND.
- Latency: request accepted at edge T gives resp_valid high from the cycle after edge T+LATENCY. For LATENCY=2, resp_valid is visible after the 2nd edge following acceptance.
- Outputs are all registered, except bus_ready and resp_valid, which decode from state.
- Address wrap: bus_addr is the full index, so there is no out-of-range case.

Decomposition:
- Shared package bus_pkg:
  - op encodings OP_READ = 0, OP_WRITEBACK = 1.
  - CPU id constants CPU1 = 0, CPU2 = 1.
  - state encodings IDLE/ACCESS/RESPOND.
  - default DATA_W/ADDR_W. The cache controllers and bus reuse these.
- One natural sub-module, mem_array: 2**ADDR_W x DATA_W register file.
  - synchronous write, combinational read.
  - synchronous reset-to-index.

Test Plan:
- Reset then read addr 5 from cpu1, LATENCY=2 -> bus_ready drops the cycle after acceptance; resp_valid rises 2 edges later with resp_data=5, resp_dst=0; resp_ack returns to IDLE; txn_count=1.
- Write-back addr 3, data 4'hA from cpu2, acked, then read addr 3 from cpu1 -> write response resp_data=A, resp_dst=1; read response resp_data=A, resp_dst=0; txn_count=2.
- Read addr 6, bus_abort one cycle after acceptance -> no resp_valid, state back to IDLE, txn_count unchanged, mem[6] still 6.
- Write-back addr 2, data 4'h7 with bus_abort asserted during ACCESS -> abort ignored; response data 7; subsequent read of addr 2 returns 7.
- Hold resp_ack low 5 cycles, then pulse it with a simultaneous bus_req -> resp_data stable throughout; the new request is accepted only on the following edge.
- Reset asserted mid-ACCESS of a write to addr 1, data F -> outputs return to reset values; read of addr 1 returns 1; txn_count=0.
